// File: rtl/dds_pkg.sv
// dds_pkg: default widths, quadrant codes, LFSR constants and quarter-wave helpers for dds_iq.
package dds_pkg;
    localparam int DEF_N_ACCUM  = 16;
    localparam int DEF_N_TUNING = 12;
    localparam int DEF_N_LUT    = 8;
    localparam int DEF_LUT_W    = 16;
    localparam int DEF_N_OUT    = 10;

    typedef enum logic [1:0] {QUAD_0 = 2'd0, QUAD_1 = 2'd1, QUAD_2 = 2'd2, QUAD_3 = 2'd3} quad_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // pi scaled by 2^30, used to build the quarter-wave table at elaboration
    localparam longint PI_Q30 = 64'sd3373259426;

    typedef struct packed {
        logic        neg;
        logic [31:0] addr;
    } quarter_t;

    function automatic quarter_t quarter_map(input logic [1:0] q, input logic [31:0] i, input int n_lut);
        quarter_t r;
        r.neg  = q inside {QUAD_2, QUAD_3};
        r.addr = q inside {QUAD_1, QUAD_3} ? ~i & ((32'd1 << n_lut) - 32'd1) : i;
        return r;
    endfunction

    // round((2^(lut_w-1)-1) * sin(pi/2 * (k+0.5) / 2^n_lut)) via a Q30 Taylor series
    function automatic longint sine_entry(input int k, input int n_lut, input int lut_w);
        longint x, x2, term, acc;
        x    = (longint'(2 * k + 1) * PI_Q30) >>> (n_lut + 2);
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int n = 1; n < 10; n++) begin
            term = -((term * x2) >>> 30) / longint'(2 * n * (2 * n + 1));
            acc += term;
        end
        return (acc * ((longint'(1) <<< (lut_w - 1)) - 1) + (longint'(1) <<< 29)) >>> 30;
    endfunction
endpackage

// File: rtl/dds_quarter_lut.sv
// dds_quarter_lut: dual-read quarter-wave sine ROM with registered outputs, shared by I and Q.
module dds_quarter_lut
    import dds_pkg::*;
#(
    parameter int N_LUT = DEF_N_LUT,
    parameter int LUT_W = DEF_LUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_LUT-1:0] addr_a,
    input  logic [N_LUT-1:0] addr_b,
    output logic [LUT_W-1:0] data_a,
    output logic [LUT_W-1:0] data_b
);
    logic [LUT_W-1:0] rom [2**N_LUT];

    for (genvar k = 0; k < 2**N_LUT; k++) begin : g_rom
        localparam logic [LUT_W-1:0] V = LUT_W'(sine_entry(k, N_LUT, LUT_W));
        assign rom[k] = V;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_a <= '0;
            data_b <= '0;
        end else begin
            data_a <= rom[addr_a];
            data_b <= rom[addr_b];
        end
    end
endmodule

// File: rtl/dds_iq.sv
// dds_iq: quadrature DDS with tuning-word handshake, BPSK phase flip and per-sample valid.
// Define DDS_IQ_DITHER_EN to add LFSR phase dither ahead of phase truncation.
module dds_iq
    import dds_pkg::*;
#(
    parameter int N_ACCUM  = DEF_N_ACCUM,
    parameter int N_TUNING = DEF_N_TUNING,
    parameter int N_LUT    = DEF_N_LUT,
    parameter int LUT_W    = DEF_LUT_W,
    parameter int N_OUT    = DEF_N_OUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [N_TUNING-1:0]     tuning_word,
    input  logic                    tw_valid,
    output logic                    tw_ready,
    input  logic                    phase_flip,
    output logic                    flip_ack,
    output logic                    out_valid,
    output logic signed [N_OUT-1:0] sine,
    output logic signed [N_OUT-1:0] cosine
);
    localparam int NP = N_LUT + 2;
    localparam logic [N_ACCUM-1:0] HALF = {1'b1, {(N_ACCUM-1){1'b0}}};

    logic [N_ACCUM-1:0]  accum;
    logic [N_TUNING-1:0] tw_active, tw_next;
    logic                tw_pend, flip_pend;
    logic [NP-1:0]       phase;
    quarter_t            s_map, c_map;
    logic                s_neg, c_neg;
    logic [LUT_W-1:0]    s_word, c_word, s_val, c_val;
    logic [2:0]          vld;
    logic                unused_addr_bits;

    assign tw_ready = ~tw_pend;

    // a word applied on an en edge takes effect from the following en edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            accum     <= '0;
            tw_active <= '0;
            tw_next   <= '0;
            tw_pend   <= 1'b0;
            flip_pend <= 1'b0;
            flip_ack  <= 1'b0;
        end else begin
            if (en)
                accum <= accum + N_ACCUM'(tw_active) + (flip_pend ? HALF : '0);
            if (en && tw_pend) begin
                tw_active <= tw_next;
                tw_pend   <= 1'b0;
            end else if (tw_valid && tw_ready) begin
                tw_next <= tuning_word;
                tw_pend <= 1'b1;
            end
            flip_pend <= en ? phase_flip : (flip_pend | phase_flip);
            flip_ack  <= en && flip_pend;
        end
    end

`ifdef DDS_IQ_DITHER_EN
    localparam int ND = N_ACCUM - NP;
    logic [15:0]        lfsr;
    logic [N_ACCUM-1:0] dithered;
    logic               unused_lfsr;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            lfsr <= LFSR_SEED;
        else if (en)
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0);
    end
    assign dithered    = accum + N_ACCUM'(lfsr[ND-1:0]);
    assign phase       = dithered[N_ACCUM-1 -: NP];
    assign unused_lfsr = ^lfsr[15:ND];
`else
    assign phase = accum[N_ACCUM-1 -: NP];
`endif

    // cosine leads sine by one quadrant
    always_comb begin
        s_map = quarter_map(phase[NP-1:NP-2], 32'(phase[N_LUT-1:0]), N_LUT);
        c_map = quarter_map(phase[NP-1:NP-2] + 2'd1, 32'(phase[N_LUT-1:0]), N_LUT);
    end

    assign unused_addr_bits = ^{s_map.addr[31:N_LUT], c_map.addr[31:N_LUT]};

    dds_quarter_lut #(.N_LUT(N_LUT), .LUT_W(LUT_W)) u_lut (
        .clk    (clk),
        .rst    (rst),
        .addr_a (s_map.addr[N_LUT-1:0]),
        .addr_b (c_map.addr[N_LUT-1:0]),
        .data_a (s_word),
        .data_b (c_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {s_neg, c_neg, s_val, c_val, vld, out_valid} <= '0;
            sine   <= '0;
            cosine <= '0;
        end else begin
            s_neg     <= s_map.neg;
            c_neg     <= c_map.neg;
            s_val     <= s_neg ? -s_word : s_word;
            c_val     <= c_neg ? -c_word : c_word;
            vld       <= {vld[1:0], en};
            out_valid <= vld[2];
            if (vld[2]) begin
                sine   <= s_val[LUT_W-1 -: N_OUT];
                cosine <= c_val[LUT_W-1 -: N_OUT];
            end
        end
    end
endmodule

// File: tb/tb_dds_iq.sv
// tb_dds_iq: randomized and directed checks of dds_iq against a sin/cos reference model.
module tb_dds_iq;
    logic               clk = 1'b0, rst = 1'b1, en = 1'b0, tw_valid = 1'b0, phase_flip = 1'b0;
    logic [15:0]        tuning_word = '0;
    logic               tw_ready, flip_ack, out_valid;
    logic signed [9:0]  sine, cosine;
    int n_checks = 0, n_fail = 0, n_ack = 0;
    int m_acc, m_tw, m_next, m_pend, m_fpend, m_ack, m_valid, m_sin, m_cos;
    int pipe_q[$];

    always #5 clk = ~clk;

    // wide tuning port so quarter-turn and half-turn steps are reachable
    dds_iq #(.N_TUNING(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .tuning_word (tuning_word),
        .tw_valid    (tw_valid),
        .tw_ready    (tw_ready),
        .phase_flip  (phase_flip),
        .flip_ack    (flip_ack),
        .out_valid   (out_valid),
        .sine        (sine),
        .cosine      (cosine)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int quant(input real v);
        int m;
        m = $rtoi(32767.0 * (v < 0.0 ? -v : v) + 0.5);
        return (v < 0.0 ? -m : m) >>> 6;
    endfunction

    task automatic model_reset();
        {m_acc, m_tw, m_next, m_pend, m_fpend, m_ack, m_valid, m_sin, m_cos} = '0;
        pipe_q = '{-1, -1, -1};
    endtask

    task automatic step();
        int  p;
        real th;
        @(posedge clk);
        m_ack = int'(en) & (m_fpend != 0 ? 1 : 0);
        if (en)
            m_acc = (m_acc + m_tw + (m_fpend != 0 ? 32768 : 0)) % 65536;
        if (en && m_pend != 0) begin
            m_tw   = m_next;
            m_pend = 0;
        end else if (tw_valid && m_pend == 0) begin
            m_next = int'(tuning_word);
            m_pend = 1;
        end
        m_fpend = en ? int'(phase_flip) : (m_fpend | int'(phase_flip));
        pipe_q.push_back(en ? m_acc : -1);
        p = pipe_q.pop_front();
        m_valid = p >= 0 ? 1 : 0;
        if (m_valid != 0) begin
            th    = 6.283185307179586 * (real'(p / 64) + 0.5) / 1024.0;
            m_sin = quant($sin(th));
            m_cos = quant($cos(th));
        end
        #1;
        if (flip_ack) n_ack++;
        check("tw_ready", int'(tw_ready), m_pend == 0 ? 1 : 0);
        check("flip_ack", int'(flip_ack), m_ack);
        check("out_valid", int'(out_valid), m_valid);
        check("sine", int'(sine), m_sin);
        check("cosine", int'(cosine), m_cos);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        en = 1'b0;
        tw_valid = 1'b0;
        phase_flip = 1'b0;
        #1;
        check("rst_sine", int'(sine), 0);
        check("rst_cosine", int'(cosine), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_flip_ack", int'(flip_ack), 0);
        check("rst_tw_ready", int'(tw_ready), 1);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic load(input int w);
        tuning_word = 16'(w);
        tw_valid = 1'b1;
        step();
        tw_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();
        // quarter-turn steps: four-point I/Q rotation
        load(16384);
        en = 1'b1;
        repeat (14) step();
        // handshake: second word waits while the first is pending
        en = 1'b0;
        load(1000);
        tuning_word = 16'd3000;
        tw_valid = 1'b1;
        step();
        check("hs_blocked", int'(tw_ready), 0);
        en = 1'b1;
        step();
        check("hs_ready_back", int'(tw_ready), 1);
        step();
        tw_valid = 1'b0;
        repeat (6) step();
        // single flip with en continuous
        load(1024);
        repeat (8) step();
        n_ack = 0;
        phase_flip = 1'b1;
        step();
        phase_flip = 1'b0;
        repeat (8) step();
        check("flip_single", n_ack, 1);
        // three-cycle request while idle merges into one flip
        en = 1'b0;
        n_ack = 0;
        phase_flip = 1'b1;
        repeat (3) step();
        phase_flip = 1'b0;
        en = 1'b1;
        repeat (8) step();
        check("flip_merged", n_ack, 1);
        // half-turn steps exercise accumulator wrap
        load(32767);
        repeat (24) step();
        // reset with pending word, pending flip and samples in flight
        en = 1'b0;
        tuning_word = 16'd777;
        tw_valid = 1'b1;
        phase_flip = 1'b1;
        step();
        do_reset();
        step();
        check("post_rst_ready", int'(tw_ready), 1);
        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            en          = $urandom_range(0, 3) != 0;
            tw_valid    = $urandom_range(0, 5) == 0;
            tuning_word = 16'($urandom);
            phase_flip  = $urandom_range(0, 15) == 0;
            if ($urandom_range(0, 499) == 0)
                do_reset();
            else
                step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
